sample_dump_streamer: RTL and testbench
=======================================

Name: sample_dump_streamer

Overview:
- Downstream readout stage for the counter-indexed sample capture buffer.
- On a start pulse, it snapshots how many samples the buffer holds and where the oldest one is.
- It then drives the buffer's asynchronous read index sequentially and streams each sample out over a valid/ready interface, marking the final beat.
- It lets software or a DMA drain a capture run without per-word register accesses.

Parameters:
- BW_DATA, 1, sample width; equals the capture buffer data width.
- DEPTH, 1, capture buffer depth in entries.
- BW_INDEX, REQUIRED_BITWIDTH_INDEX(DEPTH), read/write index width (derived, not overridden).
- BW_TOTAL, 16, width of the buffer's running sample counter.
- CIRCULAR, 0, 1 = buffer overwrites when full, so the dump starts at the oldest entry.

Ports:
- clk  input  1  clock.
- rstpp  input  1  reset. Asynchronous, active-high.
- start  input  1  single-cycle request to begin a dump.
- abort  input  1  terminate an in-progress dump.
- total_count  input  BW_TOTAL  number of samples captured since buffer reset.
- wptr  input  BW_INDEX  buffer's current write index (next slot to be written).
- rindex  output  BW_INDEX  read index to the buffer.
- rdata  input  BW_DATA  asynchronous read data for rindex.
- m_tvalid  output  1  stream data valid.
- m_tready  input  1  stream sink ready.
- m_tdata  output  BW_DATA  stream sample.
- m_tlast  output  1  final sample of this dump.
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: all outputs 0, rindex = 0, state = IDLE. Reset asynchronously aborts any dump; no done pulse is produced.
- States: IDLE and STREAM.
- Snapshot at start:
  - Accepted only in IDLE. start while busy is ignored.
  - n = min(total_count, DEPTH), computed at BW_TOTAL+1 bits with no overflow.
  - wrapped = (total_count > DEPTH).
  - base = (CIRCULAR==1 && wrapped) ? wptr : 0.
  - n and base are registered; later changes to total_count or wptr have no effect on the dump in progress.
- Empty dump (start in IDLE with n == 0): stay in IDLE, no beats, done = 1 in the next cycle.
- Non-empty dump (start in IDLE with n > 0), start sampled at edge t:
  - rindex = base during that cycle.
  - At edge t+1: m_tdata <= rdata, m_tvalid <= 1, m_tlast <= (n == 1), state <= STREAM.
  - First beat is visible from cycle t+1 (1-cycle latency).
- Read pointer:
  - Increments modulo DEPTH (DEPTH-1 -> 0) after each element is loaded into the output register.
  - rindex always presents the next element to load.
  - A remaining-element counter counts down from n.
- Handshake:
  - A beat transfers when m_tvalid && m_tready.
  - While m_tvalid && !m_tready, m_tdata, m_tlast and rindex hold.
  - On transfer of a non-last beat, the next element is loaded in the same edge, so a continuously ready sink receives one beat per cycle.
- Completion: on transfer of the beat with m_tlast = 1, at that edge m_tvalid <= 0, m_tlast <= 0, state <= IDLE, done <= 1 for one cycle.
- Abort:
  - In STREAM, at the next edge: state <= IDLE, m_tvalid <= 0, m_tlast <= 0, no done.
  - A beat transferring in the abort cycle counts as delivered.
  - start and abort in the same IDLE cycle: abort wins and no dump starts.
- busy = (state == STREAM).
- done is never asserted together with m_tvalid.
- The upstream buffer may keep capturing during a dump. Data integrity is then the user's responsibility; the block does not stall the writer.

Test Plan:
- DEPTH=8, CIRCULAR=0, total_count=5, m_tready=1 -> beats at rindex 0,1,2,3,4 on consecutive cycles, first beat one cycle after start, m_tlast on the 5th beat, done the cycle after.
- DEPTH=8, CIRCULAR=1, total_count=13, wptr=5 -> 8 beats reading indices 5,6,7,0,1,2,3,4; m_tlast on the index-4 beat.
- total_count=0, start -> no m_tvalid, done=1 exactly one cycle after start, busy stays 0.
- DEPTH=4, total_count=4, m_tready toggled 1,0,0,1,0,1,1 -> m_tdata and rindex stable during stalls, exactly 4 transfers in order, m_tlast only on the 4th.
- Abort after 2 of 6 beats -> m_tvalid 0 next cycle, no done; a new start then begins again at the base index.
- Assert rstpp mid-dump and while start is held during busy -> outputs 0 immediately on reset; the start received during busy is ignored and no second dump occurs.

Source files
------------

// File: rtl/sample_dump_streamer.sv
// Readout stage for the counter-indexed sample capture buffer.
// A start request snapshots the sample count and the oldest entry's index,
// then the block walks the buffer's asynchronous read port and streams
// every held sample over valid/ready, flagging the final beat with m_tlast.

module sample_dump_streamer #(
  parameter int BW_DATA  = 1,
  parameter int DEPTH    = 1,
  parameter int BW_INDEX = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BW_TOTAL = 16,
  parameter int CIRCULAR = 0
) (
  input  logic                clk,
  input  logic                rstpp,
  input  logic                start,
  input  logic                abort,
  input  logic [BW_TOTAL-1:0] total_count,
  input  logic [BW_INDEX-1:0] wptr,
  output logic [BW_INDEX-1:0] rindex,
  input  logic [BW_DATA-1:0]  rdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [BW_DATA-1:0]  m_tdata,
  output logic                m_tlast,
  output logic                busy,
  output logic                done
);

  // Sample counts are handled one bit wider than the running counter so
  // the clamp against DEPTH can never overflow.
  localparam int                  BW_N       = BW_TOTAL + 1;
  localparam logic [BW_N-1:0]     DEPTH_N    = BW_N'(DEPTH);
  localparam logic [BW_INDEX-1:0] LAST_INDEX = BW_INDEX'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Buffer index step, wrapping DEPTH-1 back to 0 (DEPTH need not be 2^k).
  function automatic logic [BW_INDEX-1:0] next_index(input logic [BW_INDEX-1:0] idx);
    if (idx == LAST_INDEX) begin
      next_index = {BW_INDEX{1'b0}};
    end else begin
      next_index = idx + BW_INDEX'(1);
    end
  endfunction

  state_t              state_q, state_d;
  logic [BW_INDEX-1:0] rptr_q, rptr_d;       // next element to load
  logic [BW_N-1:0]     remain_q, remain_d;   // elements not yet loaded
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [BW_DATA-1:0]  tdata_q, tdata_d;
  logic                done_q, done_d;

  logic [BW_N-1:0]     total_ext_s;
  logic                wrapped_s;
  logic [BW_N-1:0]     n_s;
  logic [BW_INDEX-1:0] base_s;
  logic                accept_s;
  logic                xfer_s;
  logic [BW_INDEX-1:0] rindex_s;

  // Snapshot values offered at start: clamped count and oldest-entry index.
  always_comb begin
    total_ext_s = {1'b0, total_count};
    wrapped_s   = (total_ext_s > DEPTH_N);
    if (wrapped_s) begin
      n_s = DEPTH_N;
    end else begin
      n_s = total_ext_s;
    end
    if ((CIRCULAR == 1) && wrapped_s) begin
      base_s = wptr;
    end else begin
      base_s = {BW_INDEX{1'b0}};
    end
  end

  // Next-state, stream register and read-pointer update logic.
  always_comb begin
    state_d  = state_q;
    rptr_d   = rptr_q;
    remain_d = remain_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    done_d   = 1'b0;
    accept_s = start && !abort;
    xfer_s   = tvalid_q && m_tready;
    rindex_s = rptr_q;

    case (state_q)
      ST_IDLE: begin
        // Present the oldest entry during the start cycle so its data can
        // be captured on the very next edge.
        if (start) begin
          rindex_s = base_s;
        end else begin
          rindex_s = {BW_INDEX{1'b0}};
        end
        if (accept_s) begin
          if (n_s == {BW_N{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_STREAM;
            tvalid_d = 1'b1;
            tdata_d  = rdata;
            tlast_d  = (n_s == BW_N'(1));
            rptr_d   = next_index(base_s);
            remain_d = n_s - BW_N'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        rindex_s = rptr_q;
        if (abort) begin
          // A beat handshaking this cycle still counts as delivered.
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else if (xfer_s) begin
          if (tlast_q) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            tdata_d  = rdata;
            tlast_d  = (remain_q == BW_N'(1));
            rptr_d   = next_index(rptr_q);
            remain_d = remain_q - BW_N'(1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        rindex_s = {BW_INDEX{1'b0}};
      end
    endcase
  end

  // State and stream registers; reset abandons any dump without a done pulse.
  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) begin
      state_q  <= ST_IDLE;
      rptr_q   <= {BW_INDEX{1'b0}};
      remain_q <= {BW_N{1'b0}};
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= {BW_DATA{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rptr_q   <= rptr_d;
      remain_q <= remain_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      done_q   <= done_d;
    end
  end

  assign rindex   = rindex_s;
  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign busy     = (state_q == ST_STREAM);
  assign done     = done_q;

endmodule

// File: tb/tb_sample_dump_streamer.sv
// Directed bench for sample_dump_streamer. Three instances share the
// stimulus: a linear 8-deep buffer, a circular 8-deep buffer and a linear
// 4-deep buffer. Each buffer's contents are modelled as 8'hA0 + index.

module tb_sample_dump_streamer;

  logic        clk = 1'b0;
  logic        rstpp;
  logic        start;
  logic        abort;
  logic [15:0] total_count;
  logic [2:0]  wptr;
  logic        m_tready;

  logic [2:0] rindex_a, rindex_b;
  logic [1:0] rindex_c;
  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic [7:0] tdata_a, tdata_b, tdata_c;
  logic       tvalid_a, tvalid_b, tvalid_c;
  logic       tlast_a, tlast_b, tlast_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rdata_a = 8'hA0 + {5'b00000, rindex_a};
  assign rdata_b = 8'hA0 + {5'b00000, rindex_b};
  assign rdata_c = 8'hA0 + {6'b000000, rindex_c};

  sample_dump_streamer #(.BW_DATA(8), .DEPTH(8), .BW_TOTAL(16), .CIRCULAR(0)) dut_a (
    .clk(clk), .rstpp(rstpp), .start(start), .abort(abort),
    .total_count(total_count), .wptr(wptr), .rindex(rindex_a), .rdata(rdata_a),
    .m_tvalid(tvalid_a), .m_tready(m_tready), .m_tdata(tdata_a), .m_tlast(tlast_a),
    .busy(busy_a), .done(done_a));

  sample_dump_streamer #(.BW_DATA(8), .DEPTH(8), .BW_TOTAL(16), .CIRCULAR(1)) dut_b (
    .clk(clk), .rstpp(rstpp), .start(start), .abort(abort),
    .total_count(total_count), .wptr(wptr), .rindex(rindex_b), .rdata(rdata_b),
    .m_tvalid(tvalid_b), .m_tready(m_tready), .m_tdata(tdata_b), .m_tlast(tlast_b),
    .busy(busy_b), .done(done_b));

  sample_dump_streamer #(.BW_DATA(8), .DEPTH(4), .BW_TOTAL(16), .CIRCULAR(0)) dut_c (
    .clk(clk), .rstpp(rstpp), .start(start), .abort(abort),
    .total_count(total_count), .wptr(wptr[1:0]), .rindex(rindex_c), .rdata(rdata_c),
    .m_tvalid(tvalid_c), .m_tready(m_tready), .m_tdata(tdata_c), .m_tlast(tlast_c),
    .busy(busy_c), .done(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int beat;

    rstpp = 1'b1; start = 1'b0; abort = 1'b0;
    total_count = 16'd0; wptr = 3'd0; m_tready = 1'b0;
    #12;
    chk("rst_valid_a", {31'd0, tvalid_a}, 32'd0);
    chk("rst_last_a", {31'd0, tlast_a}, 32'd0);
    chk("rst_data_a", {24'd0, tdata_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_rindex_a", {29'd0, rindex_a}, 32'd0);
    chk("rst_valid_bc", {30'd0, tvalid_b, tvalid_c}, 32'd0);
    chk("rst_busy_bc", {30'd0, busy_b, busy_c}, 32'd0);
    chk("rst_done_bc", {30'd0, done_b, done_c}, 32'd0);
    chk("rst_last_bc", {30'd0, tlast_b, tlast_c}, 32'd0);
    chk("rst_data_bc", {16'd0, tdata_b, tdata_c}, 32'd0);
    chk("rst_rindex_bc", {27'd0, rindex_b, rindex_c}, 32'd0);
    @(negedge clk);
    rstpp = 1'b0;
    step();

    // Linear dump of 5 samples, sink always ready.
    total_count = 16'd5; wptr = 3'd0; m_tready = 1'b1; start = 1'b1;
    #1;
    chk("t1_rindex_start", {29'd0, rindex_a}, 32'd0);
    chk("t1_valid_pre", {31'd0, tvalid_a}, 32'd0);
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", {31'd0, tvalid_a}, 32'd1);
      chk("t1_data", {24'd0, tdata_a}, 32'(8'hA0 + i));
      chk("t1_last", {31'd0, tlast_a}, 32'(i == 4));
      chk("t1_rindex", {29'd0, rindex_a}, 32'((i + 1) % 8));
      chk("t1_busy", {31'd0, busy_a}, 32'd1);
      chk("t1_done_low", {31'd0, done_a}, 32'd0);
      step();
    end
    chk("t1_valid_end", {31'd0, tvalid_a}, 32'd0);
    chk("t1_done", {31'd0, done_a}, 32'd1);
    chk("t1_busy_end", {31'd0, busy_a}, 32'd0);
    step();
    chk("t1_done_pulse", {31'd0, done_a}, 32'd0);

    // Wrapped buffer: circular starts at wptr, linear starts at 0.
    total_count = 16'd13; wptr = 3'd5; start = 1'b1;
    #1;
    chk("t2_rindex_b", {29'd0, rindex_b}, 32'd5);
    chk("t2_rindex_a", {29'd0, rindex_a}, 32'd0);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid_b", {31'd0, tvalid_b}, 32'd1);
      chk("t2_data_b", {24'd0, tdata_b}, 32'(8'hA0 + ((5 + i) % 8)));
      chk("t2_last_b", {31'd0, tlast_b}, 32'(i == 7));
      chk("t2_data_a", {24'd0, tdata_a}, 32'(8'hA0 + i));
      chk("t2_last_a", {31'd0, tlast_a}, 32'(i == 7));
      step();
    end
    chk("t2_done_b", {31'd0, done_b}, 32'd1);
    chk("t2_done_a", {31'd0, done_a}, 32'd1);
    chk("t2_valid_b_end", {31'd0, tvalid_b}, 32'd0);

    // Empty dump.
    total_count = 16'd0; wptr = 3'd0; start = 1'b1;
    #1;
    chk("t3_rindex", {29'd0, rindex_a}, 32'd0);
    step();
    start = 1'b0;
    chk("t3_valid", {31'd0, tvalid_a}, 32'd0);
    chk("t3_busy", {31'd0, busy_a}, 32'd0);
    chk("t3_done", {31'd0, done_a}, 32'd1);
    step();
    chk("t3_done_pulse", {31'd0, done_a}, 32'd0);
    chk("t3_valid_after", {31'd0, tvalid_a}, 32'd0);

    // Backpressure on the 4-deep buffer.
    total_count = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    pat = 7'b1101001;
    beat = 0;
    for (int k = 0; k < 7; k++) begin
      m_tready = pat[k];
      #1;
      chk("t4_valid", {31'd0, tvalid_c}, 32'd1);
      chk("t4_data", {24'd0, tdata_c}, 32'(8'hA0 + beat));
      chk("t4_last", {31'd0, tlast_c}, 32'(beat == 3));
      chk("t4_rindex", {30'd0, rindex_c}, 32'((beat + 1) % 4));
      step();
      if (pat[k]) beat++;
    end
    chk("t4_valid_end", {31'd0, tvalid_c}, 32'd0);
    chk("t4_done", {31'd0, done_c}, 32'd1);
    m_tready = 1'b1;
    step();

    // Abort after two beats, then restart from the base index.
    total_count = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_beat0", {24'd0, tdata_a}, 32'h0A0);
    step();
    chk("t5_beat1", {24'd0, tdata_a}, 32'h0A1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_valid_abort", {31'd0, tvalid_a}, 32'd0);
    chk("t5_busy_abort", {31'd0, busy_a}, 32'd0);
    chk("t5_last_abort", {31'd0, tlast_a}, 32'd0);
    chk("t5_done_abort", {31'd0, done_a}, 32'd0);
    step();
    chk("t5_done_later", {31'd0, done_a}, 32'd0);
    start = 1'b1;
    #1;
    chk("t5_restart_rindex", {29'd0, rindex_a}, 32'd0);
    step();
    start = 1'b0;
    chk("t5_restart_valid", {31'd0, tvalid_a}, 32'd1);
    chk("t5_restart_data", {24'd0, tdata_a}, 32'h0A0);
    chk("t5_restart_rindex1", {29'd0, rindex_a}, 32'd1);
    step();
    chk("t6_pre_rst_data", {24'd0, tdata_a}, 32'h0A1);

    // Asynchronous reset in the middle of a dump.
    #2;
    rstpp = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, tvalid_a}, 32'd0);
    chk("t6_rst_data", {24'd0, tdata_a}, 32'd0);
    chk("t6_rst_last", {31'd0, tlast_a}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_rst_rindex", {29'd0, rindex_a}, 32'd0);
    chk("t6_rst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    rstpp = 1'b0;
    step();
    chk("t6_post_rst_done", {31'd0, done_a}, 32'd0);
    chk("t6_post_rst_valid", {31'd0, tvalid_a}, 32'd0);

    // start and abort together in IDLE: no dump, no done.
    total_count = 16'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t7_valid", {31'd0, tvalid_a}, 32'd0);
    chk("t7_busy", {31'd0, busy_a}, 32'd0);
    chk("t7_done", {31'd0, done_a}, 32'd0);
    step();
    chk("t7_done_later", {31'd0, done_a}, 32'd0);

    // start while busy is ignored; snapshot of n=3 is unaffected.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t8_beat0", {24'd0, tdata_a}, 32'h0A0);
    step();
    chk("t8_beat1", {24'd0, tdata_a}, 32'h0A1);
    start = 1'b1; total_count = 16'd5;
    step();
    start = 1'b0;
    chk("t8_beat2", {24'd0, tdata_a}, 32'h0A2);
    chk("t8_last2", {31'd0, tlast_a}, 32'd1);
    step();
    chk("t8_valid_end", {31'd0, tvalid_a}, 32'd0);
    chk("t8_done", {31'd0, done_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t8_no_second_valid", {31'd0, tvalid_a}, 32'd0);
      chk("t8_no_second_busy", {31'd0, busy_a}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
